tone_synth: RTL and testbench

- Stereo square-wave tone generator with a shared attack/sustain/release envelope and a 3-bit volume control.
- Produces 16-bit signed PCM samples at the system clock rate.
- Sits directly upstream of the I2S speaker controller and drives its audio_in_left / audio_in_right inputs.
- Note pitch comes from per-channel half-period divisors supplied by the music/keyboard logic.

---
 rtl/tone_synth.sv | 198 +++++++++++++++++++
 tb/tb_tone_synth.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// -----------------------------------------------------------------------------
// tone_synth: stereo square-wave tone generator with a shared
// attack/sustain/release envelope and a 3-bit volume control. Produces 16-bit
// signed PCM at the clk rate for the I2S speaker controller.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   gate             note held (level-sensitive)
//   note_div_left    left half-period in clocks, 0 = silent
//   note_div_right   right half-period in clocks, 0 = silent
//   volume           0 = mute, 7 = full scale
//   noise_sel        (TONE_SYNTH_NOISE_EN only) use LFSR bit 0 as phase
//   audio_left/right registered signed samples
//   busy             registered, envelope not IDLE
//
// Optional build macro: TONE_SYNTH_NOISE_EN adds noise_sel and a 16-bit
// Fibonacci LFSR (taps 16,14,13,11) clocked by left-channel phase toggles.
// -----------------------------------------------------------------------------

// Per-channel half-period divider. wrap is the toggle strobe for this cycle.
module tone_div #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             phase,
    output logic             wrap
);
    logic [DIV_W-1:0] cnt;

    // Compare against the live divisor so a shrink below the count wraps at once.
    assign wrap = (div != '0) && (cnt >= div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (div == '0) begin
            cnt   <= '0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + DIV_W'(1);
        end
    end
endmodule

module tone_synth #(
    parameter int          DIV_W        = 22,
    parameter int          ENV_TICK     = 100000,
    parameter logic [15:0] AMP_MAX      = 16'h4000,
    parameter logic [15:0] ATTACK_STEP  = 16'h0100,
    parameter logic [15:0] RELEASE_STEP = 16'h0080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic [DIV_W-1:0] note_div_left,
    input  logic [DIV_W-1:0] note_div_right,
    input  logic [2:0]       volume,
`ifdef TONE_SYNTH_NOISE_EN
    input  logic             noise_sel,
`endif
    output logic [15:0]      audio_left,
    output logic [15:0]      audio_right,
    output logic             busy
);
    localparam int NUM_LANES = 2;
    localparam int TW = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

    env_state_t state, state_n;
    logic [15:0] level, level_n;
    logic [16:0] atk_sum;
    logic [TW-1:0] tcnt;
    logic env_tick;

    // ---------------- envelope tick ----------------
    assign env_tick = (tcnt == TW'(ENV_TICK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tcnt <= '0;
        else if (env_tick) tcnt <= '0;
        else               tcnt <= tcnt + TW'(1);
    end

    // ---------------- envelope FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
        end
    end

    // Gate changes are checked before env_tick so a simultaneous step is dropped.
    always_comb begin
        state_n = state;
        level_n = level;
        atk_sum = {1'b0, level} + {1'b0, ATTACK_STEP};
        case (state)
            IDLE: begin
                level_n = '0;
                if (gate) state_n = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    state_n = RELEASE;
                end else if (env_tick) begin
                    if (atk_sum >= {1'b0, AMP_MAX}) begin
                        level_n = AMP_MAX;
                        state_n = SUSTAIN;
                    end else begin
                        level_n = atk_sum[15:0];
                    end
                end
            end
            SUSTAIN: begin
                level_n = AMP_MAX;
                if (!gate) state_n = RELEASE;
            end
            RELEASE: begin
                if (gate) begin
                    state_n = ATTACK;
                end else if (env_tick) begin
                    if (level <= RELEASE_STEP) begin
                        level_n = '0;
                        state_n = IDLE;
                    end else begin
                        level_n = level - RELEASE_STEP;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                level_n = '0;
            end
        endcase
    end

    // ---------------- amplitude ----------------
    logic [15:0] scaled;
    assign scaled = (volume == 3'd0) ? 16'h0000 : (level >> (3'd7 - volume));

    // ---------------- dividers and samples ----------------
    logic [NUM_LANES-1:0][DIV_W-1:0] divs;
    logic [NUM_LANES-1:0]            phase;
    logic [NUM_LANES-1:0]            wrap;
    logic [NUM_LANES-1:0]            sel_ph;
    logic [NUM_LANES-1:0][15:0]      smp;

    assign divs = {note_div_right, note_div_left};

`ifdef TONE_SYNTH_NOISE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr <= 16'hACE1;
        else if (wrap[0]) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign sel_ph = noise_sel ? {NUM_LANES{lfsr[0]}} : phase;
`else
    assign sel_ph = phase;
`endif

    // Only the left strobe feeds the LFSR; the rest are intentionally dropped.
    logic unused_wrap;
    assign unused_wrap = ^wrap;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tone_div #(.DIV_W(DIV_W)) u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .div   (divs[i]),
            .phase (phase[i]),
            .wrap  (wrap[i])
        );
        assign smp[i] = (divs[i] == '0 || scaled == 16'h0000) ? 16'h0000 :
                        sel_ph[i] ? scaled : (16'h0000 - scaled);
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_left  <= '0;
            audio_right <= '0;
            busy        <= 1'b0;
        end else begin
            audio_left  <= smp[0];
            audio_right <= smp[1];
            busy        <= (state != IDLE);
        end
    end
endmodule

// File: tb/tb_tone_synth.sv
// -----------------------------------------------------------------------------
// tb_tone_synth: directed bench for tone_synth with ENV_TICK=4,
// ATTACK_STEP=16'h1000, RELEASE_STEP=16'h0800. cyc counts rising edges since
// the last reset release; expected values are derived by hand from it.
// -----------------------------------------------------------------------------
module tb_tone_synth;
    localparam int DIV_W = 22;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             gate;
    logic [DIV_W-1:0] note_div_left;
    logic [DIV_W-1:0] note_div_right;
    logic [2:0]       volume;
    logic [15:0]      audio_left;
    logic [15:0]      audio_right;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    tone_synth #(
        .DIV_W        (DIV_W),
        .ENV_TICK     (4),
        .AMP_MAX      (16'h4000),
        .ATTACK_STEP  (16'h1000),
        .RELEASE_STEP (16'h0800)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gate           (gate),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .volume         (volume),
        .audio_left     (audio_left),
        .audio_right    (audio_right),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    function automatic logic [15:0] mag(input logic [15:0] v);
        return v[15] ? (16'h0000 - v) : v;
    endfunction

    logic [15:0] exp_v;

    initial begin
        rst_n = 1'b0; gate = 1'b0; volume = 3'd0;
        note_div_left = '0; note_div_right = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio_l", audio_left, 16'h0000);
        chk("rst_audio_r", audio_right, 16'h0000);
        chk("rst_busy", {15'b0, busy}, 16'h0001 & 16'h0000);

        // attack / sustain, left div 3, right silent
        rst_n = 1'b1; cyc = 0;
        gate = 1'b1; volume = 3'd7; note_div_left = 22'd3; note_div_right = '0;
        run_to(2);  chk("busy_rise", {15'b0, busy}, 16'h0001);
        run_to(16); chk("attack_3000", audio_left, 16'h3000);
        for (int n = 17; n <= 28; n++) begin
            run_to(n);
            exp_v = (((n - 1) / 3) % 2 == 1) ? 16'h4000 : 16'hC000;
            chk("sustain_l", audio_left, exp_v);
            chk("silent_r", audio_right, 16'h0000);
        end

        // volume
        volume = 3'd5;
        run_to(29); chk("vol5_a", audio_left, 16'h1000);
        run_to(30); chk("vol5_b", audio_left, 16'h1000);
        run_to(31); chk("vol5_c", audio_left, 16'hF000);
        volume = 3'd0;
        for (int n = 32; n <= 35; n++) begin
            run_to(n);
            chk("vol0", audio_left, 16'h0000);
        end
        volume = 3'd7;

        // release from sustain
        run_to(36); gate = 1'b0;
        run_to(41); chk("rel_3800", mag(audio_left), 16'h3800);
        run_to(65); chk("rel_0800", mag(audio_left), 16'h0800);
        run_to(68); chk("rel_busy_hold", {15'b0, busy}, 16'h0001);
        run_to(69); chk("rel_busy_fall", {15'b0, busy}, 16'h0000);
        chk("rel_zero", audio_left, 16'h0000);

        // re-attack from mid-release
        gate = 1'b1;
        run_to(84); gate = 1'b0;
        run_to(100); gate = 1'b1;
        run_to(101); chk("reatk_2000a", mag(audio_left), 16'h2000);
        run_to(104); chk("reatk_2000b", mag(audio_left), 16'h2000);
        run_to(105); chk("reatk_3000", mag(audio_left), 16'h3000);
        chk("reatk_busy", {15'b0, busy}, 16'h0001);

        // asynchronous reset mid-operation
        #1 rst_n = 1'b0;
        #2;
        chk("arst_l", audio_left, 16'h0000);
        chk("arst_r", audio_right, 16'h0000);
        chk("arst_busy", {15'b0, busy}, 16'h0000);
        gate = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_rst_l", audio_left, 16'h0000);
        chk("post_rst_busy", {15'b0, busy}, 16'h0000);

        // silent right channel, left div 5, then divisor shrink
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; cyc = 0;
        gate = 1'b1; volume = 3'd7; note_div_left = 22'd5; note_div_right = '0;
        for (int n = 17; n <= 30; n++) begin
            run_to(n);
            exp_v = (((n - 1) / 5) % 2 == 1) ? 16'h4000 : 16'hC000;
            chk("div5_l", audio_left, exp_v);
            chk("div5_r", audio_right, 16'h0000);
        end
        note_div_left = 22'd10;
        for (int n = 31; n <= 51; n++) begin
            run_to(n);
            if (n <= 39)      exp_v = 16'hC000;
            else if (n <= 43) exp_v = 16'h4000;
            else if (n <= 47) exp_v = 16'hC000;
            else              exp_v = 16'h4000;
            chk("shrink_l", audio_left, exp_v);
            if (n == 38) note_div_left = 22'd4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
